// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle ARMv4 controller: FSM states, instruction
// field codes and datapath select values.
package ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXECR  = 4'd6,
    EXECI  = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9
  } state_t;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_UND = 2'b11;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// Data-processing cmd decode: ALU operation, raw flag-write intents, CMP
// writeback suppression and detection of commands this datapath cannot run.
module alu_decoder
  import ctrl_pkg::*;
(
  input  logic [3:0] cmd,
  input  logic       s,
  input  logic       exec,
  output logic [1:0] alu_control,
  output logic [1:0] flag_w,
  output logic       no_write,
  output logic       unsupported
);

  logic arith;

  always_comb begin
    alu_control = ALU_ADD;
    no_write    = 1'b0;
    unsupported = 1'b0;
    arith       = 1'b0;
    case (cmd)
      CMD_ADD: begin alu_control = ALU_ADD; arith = 1'b1; end
      CMD_SUB: begin alu_control = ALU_SUB; arith = 1'b1; end
      CMD_AND: alu_control = ALU_AND;
      CMD_ORR: alu_control = ALU_ORR;
      CMD_CMP: begin alu_control = ALU_SUB; arith = 1'b1; no_write = 1'b1; end
      default: unsupported = 1'b1;
    endcase
    // C/V only change for arithmetic ops; flags are written only while executing
    if (exec) begin
      flag_w = {s, s & arith};
    end else begin
      flag_w = 2'b00;
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// Main sequencer for the multicycle ARMv4 datapath: Moore FSM, memory wait
// counter with timeout abort, and datapath select / write-intent decode.
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic       mem_ready,
  output logic       IRWrite,
  output logic       NextPC,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic       PCS,
  output logic       RegW,
  output logic       MemW,
  output logic       NoWrite,
  output logic [1:0] FlagW,
  output logic       illegal,
  output logic       mem_err,
  output logic [3:0] state
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [CNT_W-1:0] CNT_LAST = TIMEOUT_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t           cur_state;
  state_t           next_state;
  logic [CNT_W-1:0] wait_cnt;
  logic             waiting;
  logic             timeout;
  logic             branch;
  logic             exec;
  logic [1:0]       dec_alu;
  logic [1:0]       dec_flag_w;
  logic             dec_no_write;
  logic             dec_unsupported;

  alu_decoder u_alu_decoder (
    .cmd        (Funct[4:1]),
    .s          (Funct[0]),
    .exec       (exec),
    .alu_control(dec_alu),
    .flag_w     (dec_flag_w),
    .no_write   (dec_no_write),
    .unsupported(dec_unsupported)
  );

  assign exec    = (cur_state == EXECR) || (cur_state == EXECI);
  assign waiting = (cur_state == FETCH) || (cur_state == MEMRD) || (cur_state == MEMWR);
  assign timeout = TIMEOUT_EN && waiting && !mem_ready && (wait_cnt == CNT_LAST);
  assign state   = cur_state;
  assign ImmSrc  = Op;
  assign RegSrc  = {Op == OP_MEM, Op == OP_BR};

  always_ff @(posedge clk) begin
    if (!reset) begin
      cur_state <= FETCH;
    end else begin
      cur_state <= next_state;
    end
  end

  // Counts consecutive unanswered memory cycles; an abort restarts the count
  always_ff @(posedge clk) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if (mem_ready || mem_err || (next_state != cur_state)) begin
      wait_cnt <= '0;
    end else if (waiting && (wait_cnt != CNT_MAX)) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end else begin
      wait_cnt <= wait_cnt;
    end
  end

  always_comb begin
    next_state = cur_state;
    IRWrite    = 1'b0;
    NextPC     = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b1;
    ALUSrcB    = SRCB_FOUR;
    ResultSrc  = RES_ALURESULT;
    ALUControl = ALU_ADD;
    RegW       = 1'b0;
    MemW       = 1'b0;
    NoWrite    = 1'b0;
    FlagW      = 2'b00;
    branch     = 1'b0;
    illegal    = 1'b0;
    mem_err    = 1'b0;
    if (!reset) begin
      next_state = FETCH;
    end else begin
      case (cur_state)
        FETCH: begin
          if (mem_ready) begin
            IRWrite    = 1'b1;
            NextPC     = 1'b1;
            next_state = DECODE;
          end else if (timeout) begin
            mem_err    = 1'b1;
            next_state = FETCH;
          end else begin
            next_state = FETCH;
          end
        end
        DECODE: begin
          case (Op)
            OP_MEM: next_state = MEMADR;
            OP_BR:  next_state = BRANCH;
            OP_DP: begin
              if (dec_unsupported) begin
                illegal    = 1'b1;
                next_state = FETCH;
              end else begin
                next_state = Funct[5] ? EXECI : EXECR;
              end
            end
            default: begin
              illegal    = 1'b1;
              next_state = FETCH;
            end
          endcase
        end
        MEMADR: begin
          ALUSrcA    = 1'b0;
          ALUSrcB    = SRCB_IMM;
          next_state = Funct[0] ? MEMRD : MEMWR;
        end
        MEMRD: begin
          AdrSrc    = 1'b1;
          ResultSrc = RES_ALUOUT;
          if (mem_ready) begin
            next_state = MEMWB;
          end else if (timeout) begin
            mem_err    = 1'b1;
            next_state = FETCH;
          end else begin
            next_state = MEMRD;
          end
        end
        MEMWB: begin
          ResultSrc  = RES_DATA;
          RegW       = 1'b1;
          next_state = FETCH;
        end
        // The store stays asserted while waiting, but never in the abort cycle
        MEMWR: begin
          AdrSrc    = 1'b1;
          ResultSrc = RES_ALUOUT;
          if (mem_ready) begin
            MemW       = 1'b1;
            next_state = FETCH;
          end else if (timeout) begin
            mem_err    = 1'b1;
            next_state = FETCH;
          end else begin
            MemW       = 1'b1;
            next_state = MEMWR;
          end
        end
        EXECR, EXECI: begin
          ALUSrcA    = 1'b0;
          ALUSrcB    = (cur_state == EXECI) ? SRCB_IMM : SRCB_REG;
          ALUControl = dec_alu;
          FlagW      = dec_flag_w;
          NoWrite    = dec_no_write;
          next_state = ALUWB;
        end
        ALUWB: begin
          ResultSrc  = RES_ALUOUT;
          RegW       = 1'b1;
          NoWrite    = dec_no_write;
          next_state = FETCH;
        end
        BRANCH: begin
          ALUSrcA    = 1'b0;
          ALUSrcB    = SRCB_IMM;
          branch     = 1'b1;
          next_state = FETCH;
        end
        default: next_state = FETCH;
      endcase
    end
    PCS = branch | (RegW & (Rd == 4'hF));
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Main sequencer for the multicycle ARMv4 datapath.
- Decodes the latched instruction fields and steps a Moore FSM through fetch/decode/execute/memory/writeback.
- Drives the datapath mux selects and raw write intents (PCS, RegW, MemW, NoWrite, FlagW) into the condition-logic block, which applies the Cond/flag gating.
- Adds memory wait handshake with a timeout abort.

Parameters:
TIMEOUT_CYCLES, 15, consecutive wait cycles before a memory abort; 0 disables the timeout.
CNT_W, $clog2(TIMEOUT_CYCLES+1), wait counter width (derived, not overridden).

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-low reset
Op  in  2  instr[27:26]: 00 data-processing, 01 memory, 10 branch, 11 illegal
Funct  in  6  instr[25:20]: [5]=I, [4:1]=cmd, [0]=S (memory: [0]=L)
Rd  in  4  instr[15:12]
mem_ready  in  1  memory completes the access this cycle
IRWrite  out  1  latch instruction
NextPC  out  1  PC update from fetch
AdrSrc  out  1  0=PC, 1=ALUResult
ALUSrcA  out  1  0=Rn, 1=PC
ALUSrcB  out  2  00=reg, 01=ext imm, 10=const 4
ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
ALUControl  out  2  00 add, 01 sub, 10 and, 11 orr
ImmSrc  out  2  equals Op
RegSrc  out  2  [0]=(Op==10), [1]=(Op==01)
PCS  out  1  Branch | (RegW & Rd==4'hF)
RegW  out  1  raw register write
MemW  out  1  raw memory write
NoWrite  out  1  CMP suppress writeback
FlagW  out  2  raw flag write enables [NZ, CV]
illegal  out  1  one-cycle pulse on undefined instruction
mem_err  out  1  one-cycle pulse on timeout abort
state  out  4  current state (debug)

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH.
- Reset:
  - While reset==0 at a clk edge: state<=FETCH, wait counter<=0.
  - While reset==0, every enable (IRWrite, NextPC, RegW, MemW, PCS, FlagW, illegal, mem_err) is forced to 0.
  - Selects follow FETCH values.
  - Reset mid-instruction abandons it with no writes.
- FETCH:
  - AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ALUControl=00, ResultSrc=10.
  - Waits until mem_ready=1. IRWrite=NextPC=1 only in that cycle, then DECODE.
- DECODE:
  - ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - Next state: Op=01 -> MEMADR; Op=00 -> EXECI if I=1 else EXECR; Op=10 -> BRANCH.
  - Op=11, or an unsupported cmd: pulse illegal, return to FETCH.
- MEMADR:
  - ALUSrcA=0, ALUSrcB=01, add.
  - L=1 -> MEMRD, else MEMWR. U bit ignored (always add).
- MEMRD: AdrSrc=1, ResultSrc=00. Waits for mem_ready, then MEMWB.
- MEMWB: ResultSrc=01, RegW=1, then FETCH.
- MEMWR:
  - AdrSrc=1, ResultSrc=00, MemW=1 every wait cycle.
  - Leaves to FETCH on mem_ready.
- EXECR / EXECI:
  - ALUSrcA=0; ALUSrcB=00 (EXECR) or 01 (EXECI).
  - cmd decode: 0100 ADD->00, 0010 SUB->01, 0000 AND->10, 1100 ORR->11, 1010 CMP->01 with NoWrite=1.
  - FlagW[1]=S; FlagW[0]=S & (add|sub|cmp). FlagW is zero in all other states.
  - Then ALUWB.
- ALUWB: ResultSrc=00, RegW=1 (NoWrite still driven for CMP), then FETCH.
- BRANCH: ALUSrcA=0, ALUSrcB=01, add, ResultSrc=10, Branch=1 (PCS=1), then FETCH.
- PCS/NoWrite: PCS asserts in ALUWB/MEMWB when Rd==15. NoWrite is 0 outside the EXEC/ALUWB states.
- Wait counter:
  - Increments on each cycle in FETCH/MEMRD/MEMWR with mem_ready=0; clears on mem_ready or a state change.
  - When counter==TIMEOUT_CYCLES-1 and mem_ready=0: pulse mem_err, next state FETCH.
  - In that abort cycle MemW/IRWrite/NextPC are forced 0.
  - Counter saturates, never wraps.
  - mem_ready=1 in the abort cycle wins: normal completion, no mem_err.
- Latency, zero-wait: DP 4 cycles, LDR 5, STR 4, B 3.
- Unused selects are held at FETCH values (don't-care, but deterministic).

Decomposition:
- Shared package ctrl_pkg holds:
  - state enum (4-bit)
  - Op encodings
  - cmd encodings
  - ALUControl encodings
  - ALUSrcB/ResultSrc encodings
- One sub-module, alu_decoder: cmd, S, exec-state flag -> ALUControl, FlagW, NoWrite, unsupported.
- FSM, wait counter and output decode stay in multicycle_controller.

Test Plan:
- ADD r1 (Op=00, I=0, cmd=0100, S=1, Rd=1), mem_ready=1 -> states FETCH,DECODE,EXECR,ALUWB; FlagW=11 in EXECR; RegW=1 in ALUWB only; PCS=0.
- LDR Rd=15 (Op=01, L=1), mem_ready low 3 cycles in MEMRD -> MEMRD held 4 cycles; MEMWB RegW=1, PCS=1, ResultSrc=01.
- STR, mem_ready never asserted, TIMEOUT=15 -> MemW=1 for 14 cycles; abort cycle has MemW=0 and mem_err=1; next state FETCH.
- CMP (cmd=1010, S=1) -> ALUControl=01, NoWrite=1, FlagW=11; B (Op=10) -> BRANCH with PCS=1, 3-cycle total.
- Op=11 -> illegal pulses once in DECODE, returns to FETCH, no RegW/MemW/FlagW.
- reset=0 asserted while in MEMWR -> next edge state=FETCH; all enables 0 while reset=0; timeout counter cleared.
